// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI slave receiver.
// Holds the frame width default, FSM state encoding and bit-count type.
// No logic; imported by the top level.
package spi_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W     = $clog2(WIDTH_DEF);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_slv_state_t;

  typedef logic [CNT_W-1:0] bitcnt_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input plus rise/fall detection.
// Latency: level valid STAGES cycles after the pin changes; edges are 1-cycle strobes.
// No backpressure: free-running sampler.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchroniser chain plus one extra flop holding the previous synchronised level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave: oversampled deserialiser (MSB first) with reply byte shifted on MISO.
// Latency: Ready_o pulses about SYNC_STAGES+2 Clk_i cycles after the last SCLK rise.
// No backpressure: Rcvd_o is overwritten by each completed frame; Ready_o is a 1-cycle strobe.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             Clk_i,
  input  logic             Rst_ni,
  input  logic             Sclk_i,
  input  logic             Mosi_i,
  input  logic             Sel_i,
  output logic             Miso_o,
  output logic             MisoEn_o,
  input  logic [WIDTH-1:0] TxBuf_i,
  output logic [WIDTH-1:0] Rcvd_o,
  output logic             Ready_o,
  output logic             Busy_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  spi_slv_state_t    state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  rx_sh, tx_sh, rcvd;
  logic              ready, miso, skip_fall;
  logic              armed, warm;
  logic [SYNC_STAGES-1:0] warm_sh;

  logic sclk_rise, sclk_fall, sclk_s_unused;
  logic sel_s, sel_rise, sel_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;
  logic start, desel;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(Clk_i), .rst_n(Rst_ni), .din(Sclk_i),
    .level(sclk_s_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sel (
    .clk(Clk_i), .rst_n(Rst_ni), .din(Sel_i),
    .level(sel_s), .rise(sel_rise), .fall(sel_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(Clk_i), .rst_n(Rst_ni), .din(Mosi_i),
    .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  // A select is only honoured once the synchronisers hold real pin values and SEL has
  // been seen low; this ignores a frame that was in flight across a reset.
  assign warm  = warm_sh[SYNC_STAGES-1];
  assign start = sel_rise && armed;
  assign desel = sel_fall || !sel_s;

  // Arming: wait for the sync chain to fill, then for SEL to be observed low
  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      warm_sh <= '0;
      armed   <= 1'b0;
    end else begin
      warm_sh <= {warm_sh[SYNC_STAGES-2:0], 1'b1};
      if (warm && !sel_s) armed <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  // FSM next-state: deselect always wins over a coincident SCLK edge
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACTIVE;
      ACTIVE:  if (desel) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    MisoEn_o = 1'b0;
    Busy_o   = 1'b0;
    if (state == ACTIVE) begin
      MisoEn_o = 1'b1;
      Busy_o   = (cnt != '0);
    end
  end

  // Receive path: sample MOSI on SCLK rise, publish the byte on the last bit
  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      cnt   <= '0;
      rx_sh <= '0;
      rcvd  <= '0;
      ready <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (state == IDLE || desel) begin
        cnt <= '0;
      end else if (sclk_rise) begin
        rx_sh <= {rx_sh[WIDTH-2:0], mosi_s};
        if (cnt == LAST_BIT) begin
          cnt   <= '0;
          rcvd  <= {rx_sh[WIDTH-2:0], mosi_s};
          ready <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Transmit path: load at select, shift on SCLK fall, reload on the last bit so
  // back-to-back frames present the new MSB without a shift on the trailing fall
  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      tx_sh     <= '0;
      miso      <= 1'b0;
      skip_fall <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        tx_sh     <= TxBuf_i;
        miso      <= TxBuf_i[WIDTH-1];
        skip_fall <= 1'b0;
      end
    end else if (!desel) begin
      if (sclk_rise && cnt == LAST_BIT) begin
        tx_sh     <= TxBuf_i;
        miso      <= TxBuf_i[WIDTH-1];
        skip_fall <= 1'b1;
      end else if (sclk_fall) begin
        if (skip_fall) begin
          skip_fall <= 1'b0;
        end else begin
          tx_sh <= {tx_sh[WIDTH-2:0], 1'b0};
          miso  <= tx_sh[WIDTH-2];
        end
      end
    end
  end

  assign Rcvd_o  = rcvd;
  assign Ready_o = ready;
  assign Miso_o  = miso;

endmodule

// File: tb/tb_spi_slave_rx.sv
module tb_spi_slave_rx;

  localparam int HALF = 5;  // SCLK half period in Clk_i cycles (SCLK = Clk_i/10)

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk, mosi;
  logic [1:0] ss;
  logic [7:0] txbuf0, txbuf1;
  logic       miso0, miso1, en0, en1, rdy0, rdy1, busy0, busy1;
  logic [7:0] rcvd0, rcvd1;
  logic       miso_bus;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int rdy_cnt0  = 0;
  int rdy_cnt1  = 0;

  always #10 clk = ~clk;

  spi_slave_rx u_slv0 (
    .Clk_i(clk), .Rst_ni(rst_n), .Sclk_i(sclk), .Mosi_i(mosi), .Sel_i(ss[0]),
    .Miso_o(miso0), .MisoEn_o(en0), .TxBuf_i(txbuf0), .Rcvd_o(rcvd0),
    .Ready_o(rdy0), .Busy_o(busy0)
  );

  spi_slave_rx u_slv1 (
    .Clk_i(clk), .Rst_ni(rst_n), .Sclk_i(sclk), .Mosi_i(mosi), .Sel_i(ss[1]),
    .Miso_o(miso1), .MisoEn_o(en1), .TxBuf_i(txbuf1), .Rcvd_o(rcvd1),
    .Ready_o(rdy1), .Busy_o(busy1)
  );

  assign miso_bus = en1 ? miso1 : (en0 ? miso0 : 1'b0);

  // Count Ready_o cycles per slave, sampled away from the active edge
  always @(negedge clk) begin
    if (rdy0 === 1'b1) rdy_cnt0++;
    if (rdy1 === 1'b1) rdy_cnt1++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total_cnt++;
    if (got !== want) $display("FAIL %s got %0h want %0h", name, got, want);
    else pass_cnt++;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic select(input logic [1:0] v);
    ss = v;
    wait_clk(10);
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      wait_clk(HALF);
      sclk = 1'b1;
      rx = {rx[6:0], miso_bus};
      wait_clk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; ss = 2'b00;
    txbuf0 = 8'h00; txbuf1 = 8'h00;
    wait_clk(3);
    chk("rst_rcvd0", 32'(rcvd0), 32'h00);
    chk("rst_rcvd1", 32'(rcvd1), 32'h00);
    chk("rst_ready", 32'({rdy1, rdy0}), 32'h0);
    chk("rst_miso", 32'({miso1, miso0}), 32'h0);
    chk("rst_en", 32'({en1, en0}), 32'h0);
    chk("rst_busy", 32'({busy1, busy0}), 32'h0);
    rst_n = 1'b1;
    wait_clk(6);
    chk("post_rst_en", 32'({en1, en0}), 32'h0);
  endtask

  task automatic test_basic();
    int r0, r1;
    logic [7:0] rx;
    r0 = rdy_cnt0; r1 = rdy_cnt1;
    select(2'b10);
    xfer_bits(8'hAA, 8, rx);
    wait_clk(5);
    select(2'b00);
    chk("basic_rcvd1", 32'(rcvd1), 32'hAA);
    chk("basic_rdy1_pulses", 32'(rdy_cnt1 - r1), 32'd1);
    chk("basic_rdy0_pulses", 32'(rdy_cnt0 - r0), 32'd0);
    chk("basic_rcvd0", 32'(rcvd0), 32'h00);
  endtask

  task automatic test_miso();
    logic [7:0] rx;
    txbuf1 = 8'h5C;
    select(2'b10);
    chk("miso_en1_sel", 32'(en1), 32'd1);
    chk("miso_en0_unsel", 32'(en0), 32'd0);
    xfer_bits(8'h00, 8, rx);
    wait_clk(5);
    chk("miso_reply", 32'(rx), 32'h5C);
    chk("miso_rcvd1", 32'(rcvd1), 32'h00);
    select(2'b00);
    chk("miso_en1_desel", 32'(en1), 32'd0);
  endtask

  task automatic test_abort();
    int r1;
    logic [7:0] rx;
    r1 = rdy_cnt1;
    select(2'b10);
    xfer_bits(8'hF0, 4, rx);
    wait_clk(5);
    chk("abort_busy_mid", 32'(busy1), 32'd1);
    select(2'b00);
    chk("abort_no_ready", 32'(rdy_cnt1 - r1), 32'd0);
    chk("abort_rcvd_kept", 32'(rcvd1), 32'h00);
    chk("abort_busy_idle", 32'(busy1), 32'd0);
    select(2'b10);
    xfer_bits(8'h3C, 8, rx);
    wait_clk(5);
    select(2'b00);
    chk("abort_next_rcvd", 32'(rcvd1), 32'h3C);
    chk("abort_next_ready", 32'(rdy_cnt1 - r1), 32'd1);
  endtask

  task automatic test_back_to_back();
    int r1;
    logic [7:0] rx;
    r1 = rdy_cnt1;
    txbuf1 = 8'hA5;
    select(2'b10);
    txbuf1 = 8'h3E;
    xfer_bits(8'h01, 8, rx);
    chk("b2b_reply1", 32'(rx), 32'hA5);
    chk("b2b_rcvd1", 32'(rcvd1), 32'h01);
    chk("b2b_ready1", 32'(rdy_cnt1 - r1), 32'd1);
    xfer_bits(8'h80, 8, rx);
    wait_clk(5);
    chk("b2b_reply2", 32'(rx), 32'h3E);
    chk("b2b_rcvd2", 32'(rcvd1), 32'h80);
    chk("b2b_ready2", 32'(rdy_cnt1 - r1), 32'd2);
    select(2'b00);
  endtask

  task automatic test_reset_midframe();
    int r1;
    logic [7:0] rx;
    txbuf1 = 8'hFF;
    select(2'b10);
    xfer_bits(8'hC3, 5, rx);
    rst_n = 1'b0;
    #1;
    chk("mrst_rcvd1", 32'(rcvd1), 32'h00);
    chk("mrst_en1", 32'(en1), 32'd0);
    chk("mrst_busy1", 32'(busy1), 32'd0);
    chk("mrst_miso1", 32'(miso1), 32'd0);
    wait_clk(2);
    rst_n = 1'b1;
    r1 = rdy_cnt1;
    wait_clk(10);
    xfer_bits(8'hC3, 3, rx);
    wait_clk(5);
    chk("mrst_no_ready", 32'(rdy_cnt1 - r1), 32'd0);
    chk("mrst_idle_en", 32'(en1), 32'd0);
    chk("mrst_idle_busy", 32'(busy1), 32'd0);
    select(2'b00);
    select(2'b10);
    xfer_bits(8'hC3, 8, rx);
    wait_clk(5);
    select(2'b00);
    chk("mrst_fresh_rcvd", 32'(rcvd1), 32'hC3);
    chk("mrst_fresh_ready", 32'(rdy_cnt1 - r1), 32'd1);
  endtask

  task automatic test_idle_sclk();
    int r0, r1;
    logic [7:0] rx;
    r0 = rdy_cnt0; r1 = rdy_cnt1;
    ss = 2'b00;
    xfer_bits(8'hFF, 8, rx);
    wait_clk(5);
    chk("idle_en", 32'({en1, en0}), 32'h0);
    chk("idle_busy", 32'({busy1, busy0}), 32'h0);
    chk("idle_ready", 32'((rdy_cnt1 - r1) + (rdy_cnt0 - r0)), 32'd0);
    chk("idle_rcvd1", 32'(rcvd1), 32'hC3);
    chk("idle_rcvd0", 32'(rcvd0), 32'h00);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_miso();
    test_abort();
    test_back_to_back();
    test_reset_midframe();
    test_idle_sclk();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
